// File: rtl/cam_gray_pipe_if.sv
// cam_gray_pipe_if: raster pixel stream (negative frame sync, pixel valid, RGB565 word).
// master drives the stream, slave receives it.
interface cam_gray_pipe_if;
    logic        vs_n;
    logic        de;
    logic [15:0] data;

    modport master (output vs_n, de, data);
    modport slave  (input  vs_n, de, data);
endinterface

// File: rtl/cam_gray_pipe.sv
// cam_gray_pipe: RGB565 -> 8-bit luma, re-packed as grey RGB565 (or binarised when
// CAM_GRAY_THRESHOLD_EN is defined), fixed 3-cycle latency, plus output-side x/y/frame tracking.
module cam_gray_pipe #(
    parameter int unsigned H_RES  = 1280,
    parameter int unsigned V_RES  = 720,
    parameter logic [7:0]  THRESH = 8'd128
) (
    input  logic              I_pxl_clk,
    input  logic              I_rst_n,
    cam_gray_pipe_if.slave    cam,
    cam_gray_pipe_if.master   fb,
    output logic [11:0]       O_x,
    output logic [11:0]       O_y,
    output logic [7:0]        O_frame_cnt,
    output logic              O_frame_err
);

`ifdef CAM_GRAY_THRESHOLD_EN
    localparam bit BIN_EN = 1'b1;
`else
    localparam bit BIN_EN = 1'b0;
`endif

    localparam logic [7:0] COEF [3] = '{8'd77, 8'd150, 8'd29};

    // Channel expansion to 8 bits by replicating the MSBs into the vacated LSBs.
    logic [7:0] rgb8 [3];
    always_comb begin
        rgb8[0] = {cam.data[15:11], cam.data[15:13]};
        rgb8[1] = {cam.data[10:5],  cam.data[10:9]};
        rgb8[2] = {cam.data[4:0],   cam.data[4:2]};
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_ch
            logic [7:0]  ch_reg;
            logic [15:0] prod_reg;
            always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
                if (!I_rst_n) begin
                    ch_reg   <= '0;
                    prod_reg <= '0;
                end else begin
                    ch_reg   <= rgb8[gi];
                    prod_reg <= 16'(ch_reg) * 16'(COEF[gi]);
                end
            end
        end
    endgenerate

    logic        s1_de_reg, s1_vs_reg, s2_de_reg, s2_vs_reg, de3_reg, vs3_reg;
    logic [15:0] data_reg, data_next;
    // fill_reg[2] marks that vs3_reg holds a sampled value rather than its reset value,
    // so a low vs_n at reset release is not mistaken for a frame start.
    logic [2:0]  fill_reg;
    logic [11:0] x_cnt_reg, x_cnt_next, y_cnt_reg, y_cnt_next;
    logic [11:0] x_out_reg, x_out_next, y_out_reg, y_out_next;
    logic [7:0]  frame_cnt_reg, frame_cnt_next;
    logic        err_reg, err_next, line_bad_reg, line_bad_next, started_reg, started_next;
    logic [7:0]  y_w;
    logic        fs_w, le_w;

    // Sum of the three weighted channels peaks at 65280, so 16 bits never overflow.
    assign y_w  = 8'((g_ch[0].prod_reg + g_ch[1].prod_reg + g_ch[2].prod_reg) >> 8);
    assign fs_w = fill_reg[2] & vs3_reg & ~s2_vs_reg;
    assign le_w = started_reg & de3_reg & ~s2_de_reg;

    always_comb begin
        data_next      = '0;
        x_cnt_next     = x_cnt_reg;
        y_cnt_next     = y_cnt_reg;
        x_out_next     = x_out_reg;
        y_out_next     = y_out_reg;
        frame_cnt_next = frame_cnt_reg;
        err_next       = err_reg;
        line_bad_next  = line_bad_reg;
        started_next   = started_reg;

        if (s2_de_reg) begin
            if (BIN_EN) data_next = (y_w >= THRESH) ? 16'hFFFF : 16'h0000;
            else        data_next = {y_w[7:3], y_w[7:2], y_w[7:3]};
        end

        if (le_w) begin
            if (x_cnt_reg != 12'(H_RES)) line_bad_next = 1'b1;
            if (y_cnt_reg != 12'hFFF)    y_cnt_next = y_cnt_reg + 12'd1;
            x_cnt_next = '0;
        end

        // Frame start judges the frame just closed, including a line ending this same cycle.
        if (fs_w) begin
            if (started_reg && ((y_cnt_next != 12'(V_RES)) || line_bad_next)) err_next = 1'b1;
            frame_cnt_next = frame_cnt_reg + 8'd1;
            started_next   = 1'b1;
            x_cnt_next     = '0;
            y_cnt_next     = '0;
            line_bad_next  = 1'b0;
        end

        if (s2_de_reg && started_next) begin
            x_out_next = x_cnt_next;
            y_out_next = y_cnt_next;
            if (x_cnt_next != 12'hFFF) x_cnt_next = x_cnt_next + 12'd1;
        end
    end

    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            s1_de_reg     <= 1'b0;
            s1_vs_reg     <= 1'b1;
            s2_de_reg     <= 1'b0;
            s2_vs_reg     <= 1'b1;
            de3_reg       <= 1'b0;
            vs3_reg       <= 1'b1;
            data_reg      <= '0;
            fill_reg      <= '0;
            x_cnt_reg     <= '0;
            y_cnt_reg     <= '0;
            x_out_reg     <= '0;
            y_out_reg     <= '0;
            frame_cnt_reg <= '0;
            err_reg       <= 1'b0;
            line_bad_reg  <= 1'b0;
            started_reg   <= 1'b0;
        end else begin
            s1_de_reg     <= cam.de;
            s1_vs_reg     <= cam.vs_n;
            s2_de_reg     <= s1_de_reg;
            s2_vs_reg     <= s1_vs_reg;
            de3_reg       <= s2_de_reg;
            vs3_reg       <= s2_vs_reg;
            data_reg      <= data_next;
            fill_reg      <= {fill_reg[1:0], 1'b1};
            x_cnt_reg     <= x_cnt_next;
            y_cnt_reg     <= y_cnt_next;
            x_out_reg     <= x_out_next;
            y_out_reg     <= y_out_next;
            frame_cnt_reg <= frame_cnt_next;
            err_reg       <= err_next;
            line_bad_reg  <= line_bad_next;
            started_reg   <= started_next;
        end
    end

    assign fb.vs_n     = vs3_reg;
    assign fb.de       = de3_reg;
    assign fb.data     = data_reg;
    assign O_x         = x_out_reg;
    assign O_y         = y_out_reg;
    assign O_frame_cnt = frame_cnt_reg;
    assign O_frame_err = err_reg;

endmodule

// File: tb/tb_cam_gray_pipe.sv
// tb_cam_gray_pipe: table vectors, hand-written frame sequences and random stream checked
// against a behavioural model of the pixel/frame rules, using a small frame geometry.
module tb_cam_gray_pipe;
    localparam int H = 8;
    localparam int V = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cam_gray_pipe_if cam_bus ();
    cam_gray_pipe_if fb_bus ();
    logic [11:0] o_x, o_y;
    logic [7:0]  o_fcnt;
    logic        o_err;

    cam_gray_pipe #(.H_RES(H), .V_RES(V), .THRESH(8'd128)) dut (
        .I_pxl_clk   (clk),
        .I_rst_n     (rst_n),
        .cam         (cam_bus),
        .fb          (fb_bus),
        .O_x         (o_x),
        .O_y         (o_y),
        .O_frame_cnt (o_fcnt),
        .O_frame_err (o_err)
    );

    typedef struct {
        logic        vs_n;
        logic        de;
        logic [15:0] data;
        logic        chk_xy;
        logic [11:0] x;
        logic [11:0] y;
        logic [7:0]  fcnt;
        logic        err;
    } exp_t;

    typedef struct {
        logic [15:0] din;
        logic [15:0] grey;
        logic [7:0]  y;
    } vec_t;

    exp_t exp_q[$];
    vec_t tab[7];
    int total = 0;
    int bad = 0;

    // Model state, expressed over the input stream (output is the same stream 3 cycles later).
    bit m_prev_valid, m_prev_vs, m_prev_de, m_started, m_line_bad, m_err;
    int m_pix, m_lines, m_fcnt;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] pix_model(input logic [15:0] d);
        int r8, g8, b8, lum;
        logic [7:0] y8;
        r8  = int'(d[15:11]) * 8 + int'(d[15:13]);
        g8  = int'(d[10:5]) * 4 + int'(d[10:9]);
        b8  = int'(d[4:0]) * 8 + int'(d[4:2]);
        lum = (77 * r8 + 150 * g8 + 29 * b8) / 256;
        y8  = 8'(lum);
`ifdef CAM_GRAY_THRESHOLD_EN
        return (lum >= 128) ? 16'hFFFF : 16'h0000;
`else
        return {y8[7:3], y8[7:2], y8[7:3]};
`endif
    endfunction

    function automatic void push_seed();
        exp_t e;
        e.vs_n = 1'b1; e.de = 1'b0; e.data = '0; e.chk_xy = 1'b0;
        e.x = '0; e.y = '0; e.fcnt = '0; e.err = 1'b0;
        exp_q.push_back(e);
    endfunction

    function automatic void model_push(input logic vs, input logic de, input logic [15:0] exp_data);
        exp_t e;
        bit fall;
        fall = m_prev_valid && m_prev_vs && !vs;
        if (m_started && m_prev_de && !de) begin
            if (m_pix != H) m_line_bad = 1'b1;
            m_lines++;
            m_pix = 0;
        end
        if (fall) begin
            if (m_started && (m_lines != V || m_line_bad)) m_err = 1'b1;
            m_fcnt     = (m_fcnt + 1) % 256;
            m_started  = 1'b1;
            m_lines    = 0;
            m_pix      = 0;
            m_line_bad = 1'b0;
        end
        e.vs_n   = vs;
        e.de     = de;
        e.data   = de ? exp_data : 16'h0000;
        e.chk_xy = de && m_started;
        e.x      = 12'((m_pix > 4095) ? 4095 : m_pix);
        e.y      = 12'((m_lines > 4095) ? 4095 : m_lines);
        if (de && m_started) m_pix++;
        e.fcnt   = 8'(m_fcnt);
        e.err    = m_err;
        exp_q.push_back(e);
        m_prev_valid = 1'b1;
        m_prev_vs    = vs;
        m_prev_de    = de;
    endfunction

    task automatic cycle(input logic vs, input logic de, input logic [15:0] d, input logic [15:0] exp_data);
        exp_t e;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL queue_underflow: got 0 want 1 at %0t", $time);
        end else begin
            e = exp_q.pop_front();
            chk("vs_n", int'(fb_bus.vs_n), int'(e.vs_n));
            chk("de", int'(fb_bus.de), int'(e.de));
            chk("data", int'(fb_bus.data), int'(e.data));
            if (e.chk_xy) begin
                chk("x", int'(o_x), int'(e.x));
                chk("y", int'(o_y), int'(e.y));
            end
            chk("frame_cnt", int'(o_fcnt), int'(e.fcnt));
            chk("frame_err", int'(o_err), int'(e.err));
        end
        cam_bus.vs_n = vs;
        cam_bus.de   = de;
        cam_bus.data = d;
        model_push(vs, de, exp_data);
    endtask

    task automatic pix(input logic vs, input logic de, input logic [15:0] d);
        cycle(vs, de, d, pix_model(d));
    endtask

    // Asserts reset mid-cycle, checks the asynchronous clear, releases on a falling edge.
    task automatic do_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_vs_n", int'(fb_bus.vs_n), 1);
        chk("rst_de", int'(fb_bus.de), 0);
        chk("rst_data", int'(fb_bus.data), 0);
        chk("rst_fcnt", int'(o_fcnt), 0);
        chk("rst_err", int'(o_err), 0);
        repeat (3) @(negedge clk);
        exp_q.delete();
        m_prev_valid = 0; m_prev_vs = 1; m_prev_de = 0; m_started = 0;
        m_line_bad = 0; m_err = 0; m_pix = 0; m_lines = 0; m_fcnt = 0;
        push_seed();
        push_seed();
        rst_n = 1'b1;
        model_push(cam_bus.vs_n, cam_bus.de, pix_model(cam_bus.data));
    endtask

    task automatic line(input int n);
        repeat (2) pix(1'b0, 1'b0, 16'($urandom));
        for (int p = 0; p < n; p++) pix(1'b0, 1'b1, 16'($urandom));
    endtask

    task automatic frame(input int nlines, input int short_line);
        repeat (2) pix(1'b1, 1'b0, 16'h0000);
        for (int l = 0; l < nlines; l++) line((l == short_line) ? H - 1 : H);
        repeat (2) pix(1'b0, 1'b0, 16'h0000);
    endtask

    task automatic drain();
        repeat (4) pix(1'b1, 1'b0, 16'h0000);
    endtask

    initial begin
        logic v;
        int fc_before;
        logic [15:0] ex;

        tab[0] = '{16'hF800, 16'h4A69, 8'd76};
        tab[1] = '{16'hFFFF, 16'hFFFF, 8'd255};
        tab[2] = '{16'h0000, 16'h0000, 8'd0};
        tab[3] = '{16'h07E0, 16'h94B2, 8'd149};
        tab[4] = '{16'h001F, 16'h18E3, 8'd28};
        tab[5] = '{16'h8410, 16'h8410, 8'd130};
        tab[6] = '{16'h7BEF, 16'h7BEF, 8'd124};

        cam_bus.vs_n = 1'b1;
        cam_bus.de   = 1'b0;
        cam_bus.data = '0;
        do_reset();
        repeat (5) pix(1'b1, 1'b0, 16'h0000);

        // Single-cycle pixels: output must appear exactly 3 cycles later with the table value.
        for (int i = 0; i < 7; i++) begin
`ifdef CAM_GRAY_THRESHOLD_EN
            ex = (tab[i].y >= 8'd128) ? 16'hFFFF : 16'h0000;
`else
            ex = tab[i].grey;
`endif
            cycle(1'b1, 1'b1, tab[i].din, ex);
            repeat (4) pix(1'b1, 1'b0, 16'h0000);
        end
        cycle(1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
        cycle(1'b1, 1'b1, 16'h0000, 16'h0000);
        drain();

        // Two well-formed frames, then a frame with one short line.
        frame(V, -1);
        drain();
        chk("fcnt_one", int'(o_fcnt), 1);
        frame(V, -1);
        drain();
        chk("fcnt_two", int'(o_fcnt), 2);
        frame(V, 1);
        drain();
        chk("err_after_good", int'(o_err), 0);
        frame(V, -1);
        drain();
        chk("err_short_line", int'(o_err), 1);
        frame(V, -1);
        frame(V, -1);
        drain();
        chk("err_held", int'(o_err), 1);
        chk("fcnt_six", int'(o_fcnt), 6);

        // Wrong line count.
        do_reset();
        frame(V - 1, -1);
        frame(V, -1);
        drain();
        chk("err_line_count", int'(o_err), 1);

        // Reset in the middle of a frame: nothing counts until the next vs_n fall.
        do_reset();
        frame(V, -1);
        line(H);
        do_reset();
        line(H);
        line(H);
        repeat (2) pix(1'b0, 1'b0, 16'h0000);
        chk("midrst_fcnt", int'(o_fcnt), 0);
        drain();
        frame(V, -1);
        drain();
        chk("midrst_resume", int'(o_fcnt), 1);
        chk("midrst_err", int'(o_err), 0);

        // Column saturation on an overlong line.
        repeat (2) pix(1'b1, 1'b0, 16'h0000);
        line(4100);
        drain();

        // Random stream with sparse vs_n toggles.
        v = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(49) == 0) v = ~v;
            pix(v, 1'($urandom_range(3) != 0), 16'($urandom));
        end

        // vs_n held low: no further frame starts.
        repeat (3) pix(1'b0, 1'b0, 16'h0000);
        fc_before = m_fcnt;
        for (int i = 0; i < 400; i++) pix(1'b0, 1'($urandom_range(1)), 16'($urandom));
        repeat (3) pix(1'b0, 1'b0, 16'h0000);
        chk("vs_low_fcnt", int'(o_fcnt), fc_before);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
